// File: rtl/tile_lookup_arbiter.sv
// Round-robin arbiter sharing the tile map read port between movement/collision clients.
// Lookups are pipelined to the map read latency; off-map coordinates return the border code.
module tile_lookup_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ROWS         = 12,
    parameter int COLS         = 17,
    parameter int ROW_BITS     = 4,
    parameter int COL_BITS     = 5,
    parameter int TILE_BITS    = 8,
    parameter int READ_LATENCY = 1,
    parameter logic [TILE_BITS-1:0] BDR = '0
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*ROW_BITS-1:0]  req_row_i,
    input  logic [NUM_REQ*COL_BITS-1:0]  req_col_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [TILE_BITS-1:0]         rsp_tile_o,
    output logic                         mem_rd_en_o,
    output logic [ROW_BITS-1:0]          mem_row_o,
    output logic [COL_BITS-1:0]          mem_col_o,
    input  logic [TILE_BITS-1:0]         mem_tile_i,
    output logic                         busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 oor_q, oor_d;
    logic                 rd_en_q, rd_en_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [NUM_REQ-1:0]   tag_cli_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] tag_oor_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [TILE_BITS-1:0] rsp_tile_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   inflight;
    logic [NUM_REQ-1:0]   eligible;

    // A client is in flight from its grant cycle until the cycle before its response.
    always_comb begin
        inflight = gnt_q;
        for (int k = 0; k < READ_LATENCY; k++) begin
            inflight = inflight | tag_cli_q[k];
        end
        eligible = req_i & ~inflight;
    end

    always_comb begin : arb
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt_d = '0;
        ptr_d = ptr_q;
        row_d = row_q;
        col_d = col_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                gnt_d[idx] = 1'b1;
                ptr_d      = PTR_W'(idx);
                row_d      = req_row_i[idx*ROW_BITS +: ROW_BITS];
                col_d      = req_col_i[idx*COL_BITS +: COL_BITS];
            end
        end
        oor_d   = !((int'(row_d) < ROWS) && (int'(col_d) < COLS));
        rd_en_d = found && !oor_d;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            oor_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            tag_oor_q   <= '0;
            rsp_valid_q <= '0;
            rsp_tile_q  <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_cli_q[k] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            oor_q        <= oor_d;
            rd_en_q      <= rd_en_d;
            row_q        <= row_d;
            col_q        <= col_d;
            tag_cli_q[0] <= gnt_q;
            tag_oor_q[0] <= oor_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_cli_q[k] <= tag_cli_q[k-1];
                tag_oor_q[k] <= tag_oor_q[k-1];
            end
            rsp_valid_q <= tag_cli_q[READ_LATENCY-1];
            if (|tag_cli_q[READ_LATENCY-1]) begin
                rsp_tile_q <= tag_oor_q[READ_LATENCY-1] ? BDR : mem_tile_i;
            end
            // Busy covers the grant cycle through the response cycle.
            busy_q <= (|gnt_d) | (|inflight);
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tile_o  = rsp_tile_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_row_o   = row_q;
    assign mem_col_o   = col_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_tile_lookup_arbiter.sv
// Scoreboard bench for tile_lookup_arbiter: two instances (read latency 1 and 3) run
// randomized client traffic against a timestamp-based round-robin reference model.
module tb_tile_lookup_arbiter;

    localparam int NR   = 3;
    localparam int RB   = 4;
    localparam int CB   = 5;
    localparam int TW   = 8;
    localparam int NROW = 12;
    localparam int NCOL = 17;

    typedef struct {
        int            cyc;
        int            gcyc;
        int            cli;
        logic          rd;
        logic [RB-1:0] row;
        logic [CB-1:0] col;
        logic [TW-1:0] tile;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [TW-1:0] tmap [NROW][NCOL];

    function automatic void chk(input int lat, input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL lat%0d %s got=%0d exp=%0d (cycle %0d)", lat, n, got, exp, cyc);
        end
    endfunction

    function automatic void fail(input int lat, input string n);
        checks++;
        failures++;
        $display("FAIL lat%0d %s (cycle %0d)", lat, n, cyc);
    endfunction

    function automatic logic [RB-1:0] rand_row();
        if ($urandom_range(0, 7) == 0) return RB'($urandom_range(12, 15));
        return RB'($urandom_range(0, 11));
    endfunction

    function automatic logic [CB-1:0] rand_col();
        if ($urandom_range(0, 7) == 0) return CB'($urandom_range(17, 31));
        return CB'($urandom_range(0, 16));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic             rst;
        logic [NR-1:0]    req;
        logic [NR*RB-1:0] rrow;
        logic [NR*CB-1:0] rcol;
        logic [NR-1:0]    gnt, rv;
        logic [TW-1:0]    rtile, mtile;
        logic             rd;
        logic [RB-1:0]    mrow;
        logic [CB-1:0]    mcol;
        logic             busy;
        logic [TW-1:0]    mpipe [LAT];
        item_t            gq[$];
        item_t            rq[$];
        int               ptr;
        int               next_ok [NR];
        int               p_raise [NR];
        int               p_keep  [NR];
        bit               done_l = 1'b0;

        tile_lookup_arbiter #(
            .NUM_REQ(NR), .ROWS(NROW), .COLS(NCOL), .ROW_BITS(RB), .COL_BITS(CB),
            .TILE_BITS(TW), .READ_LATENCY(LAT), .BDR(8'h00)
        ) dut (
            .clock_i(clk), .reset_i(rst), .req_i(req), .req_row_i(rrow), .req_col_i(rcol),
            .gnt_o(gnt), .rsp_valid_o(rv), .rsp_tile_o(rtile), .mem_rd_en_o(rd),
            .mem_row_o(mrow), .mem_col_o(mcol), .mem_tile_i(mtile), .busy_o(busy)
        );

        // Map memory: data appears LAT cycles after the read strobe; junk otherwise.
        always @(posedge clk) begin
            mpipe[0] <= (rd && mrow < NROW && mcol < NCOL) ? tmap[mrow][mcol] : 8'hFF;
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
        assign mtile = mpipe[LAT-1];

        task automatic set_req(input int i, input logic [RB-1:0] r, input logic [CB-1:0] c);
            req[i]          = 1'b1;
            rrow[i*RB +: RB] = r;
            rcol[i*CB +: CB] = c;
        endtask

        task automatic set_p(input int pr, input int pk);
            for (int i = 0; i < NR; i++) begin
                p_raise[i] = pr;
                p_keep[i]  = pk;
            end
        endtask

        task automatic edge_begin();
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (gnt[i]) begin
                    if (int'($urandom_range(1, 100)) <= p_keep[i]) set_req(i, rand_row(), rand_col());
                    else req[i] = 1'b0;
                end else if (!req[i] && int'($urandom_range(1, 100)) <= p_raise[i]) begin
                    set_req(i, rand_row(), rand_col());
                end
            end
        endtask

        // Reference: round-robin over clients whose previous response is out (or due now).
        task automatic decide();
            int    c;
            bit    found;
            item_t it;
            c     = cyc;
            found = 1'b0;
            if (rst) return;
            for (int off = 1; off <= NR; off++) begin
                int idx;
                idx = (ptr + off) % NR;
                if (!found && req[idx] && c >= next_ok[idx]) begin
                    found   = 1'b1;
                    it.cli  = idx;
                    it.row  = rrow[idx*RB +: RB];
                    it.col  = rcol[idx*CB +: CB];
                    it.rd   = (it.row < NROW) && (it.col < NCOL);
                    it.tile = it.rd ? tmap[it.row][it.col] : 8'h00;
                    it.gcyc = c + 1;
                    it.cyc  = c + 1;
                    gq.push_back(it);
                    it.cyc  = c + LAT + 2;
                    rq.push_back(it);
                    next_ok[idx] = c + LAT + 2;
                    ptr = idx;
                end
            end
        endtask

        task automatic run(input int n);
            repeat (n) begin
                edge_begin();
                decide();
            end
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst = 1'b1;
            req = '0;
            gq.delete();
            rq.delete();
            ptr = NR - 1;
            for (int i = 0; i < NR; i++) next_ok[i] = 0;
            #1;
            chk(LAT, "rst_gnt", gnt, 0);
            chk(LAT, "rst_rsp_valid", rv, 0);
            chk(LAT, "rst_rsp_tile", rtile, 0);
            chk(LAT, "rst_mem_rd_en", rd, 0);
            chk(LAT, "rst_mem_row", mrow, 0);
            chk(LAT, "rst_mem_col", mcol, 0);
            chk(LAT, "rst_busy", busy, 0);
            @(negedge clk);
            rst = 1'b0;
        endtask

        initial begin
            rst  = 1'b1;
            req  = '0;
            rrow = '0;
            rcol = '0;
            ptr  = NR - 1;
            set_p(0, 0);
            for (int i = 0; i < NR; i++) next_ok[i] = 0;

            // Single in-range lookup: client 0 at (3,5).
            do_reset();
            decide();
            edge_begin(); set_req(0, 4'd3, 5'd5); decide();
            run(6);

            // Off-map lookups from client 1: row 12, then column 17.
            edge_begin(); set_req(1, 4'd12, 5'd4); decide();
            run(5);
            edge_begin(); set_req(1, 4'd2, 5'd17); decide();
            run(6);

            // All clients requesting continuously straight out of reset.
            do_reset();
            set_p(100, 100);
            for (int i = 0; i < NR; i++) set_req(i, rand_row(), rand_col());
            decide();
            run(20);
            set_p(0, 0);
            run(12);

            // Reset while clients 0 and 2 are in flight, then only client 2 requests.
            do_reset();
            decide();
            edge_begin(); set_req(0, rand_row(), rand_col()); set_req(2, rand_row(), rand_col()); decide();
            edge_begin(); decide();
            do_reset();
            set_req(2, 4'd1, 5'd1);
            decide();
            @(posedge clk); #1;
            chk(LAT, "post_reset_first_gnt", gnt, 3'b100);
            run(10);

            // Client 0 held, client 1 toggling.
            p_raise[0] = 100; p_keep[0] = 100;
            p_raise[1] = 50;  p_keep[1] = 50;
            p_raise[2] = 0;   p_keep[2] = 0;
            run(200);

            // Fully random traffic.
            for (int i = 0; i < NR; i++) begin
                p_raise[i] = int'($urandom_range(20, 90));
                p_keep[i]  = int'($urandom_range(20, 90));
            end
            run(1000);

            set_p(0, 0);
            run(20);
            chk(LAT, "gnt_queue_drained", gq.size(), 0);
            chk(LAT, "rsp_queue_drained", rq.size(), 0);
            done_l = 1'b1;
        end

        // Monitor: compares every presented grant/response against the scoreboard.
        initial begin
            int    d;
            int    last_g [NR];
            bit    seen   [NR];
            int    waitc  [NR];
            bit    expb;
            bit    elig;
            item_t it;
            for (int i = 0; i < NR; i++) begin
                last_g[i] = 0; seen[i] = 1'b0; waitc[i] = 0;
            end
            forever begin
                @(posedge clk); #1;
                d = cyc;
                if (rst !== 1'b0) begin
                    for (int i = 0; i < NR; i++) begin
                        seen[i] = 1'b0; waitc[i] = 0;
                    end
                    continue;
                end

                expb = 1'b0;
                foreach (rq[k]) if (rq[k].gcyc <= d && d <= rq[k].cyc) expb = 1'b1;
                chk(LAT, "busy", busy, expb);

                while (gq.size() > 0 && gq[0].cyc < d) begin
                    fail(LAT, "gnt_missing");
                    void'(gq.pop_front());
                end
                if (gnt != '0) begin
                    if (gq.size() > 0 && gq[0].cyc == d) begin
                        it = gq.pop_front();
                        chk(LAT, "gnt_client", gnt, 1 << it.cli);
                        chk(LAT, "mem_rd_en", rd, it.rd);
                        if (it.rd) begin
                            chk(LAT, "mem_row", mrow, it.row);
                            chk(LAT, "mem_col", mcol, it.col);
                        end
                    end else begin
                        fail(LAT, "gnt_unexpected");
                    end
                end else begin
                    chk(LAT, "mem_rd_en_idle", rd, 0);
                end

                while (rq.size() > 0 && rq[0].cyc < d) begin
                    fail(LAT, "rsp_missing");
                    void'(rq.pop_front());
                end
                if (rv != '0) begin
                    if (rq.size() > 0 && rq[0].cyc == d) begin
                        it = rq.pop_front();
                        chk(LAT, "rsp_valid_client", rv, 1 << it.cli);
                        chk(LAT, "rsp_tile", rtile, it.tile);
                    end else begin
                        fail(LAT, "rsp_unexpected");
                    end
                end

                // Fairness: an eligible client sees at most NR-1 grants to others before its own.
                for (int i = 0; i < NR; i++) begin
                    elig = req[i] && !(seen[i] && (d - 1) < last_g[i] + LAT + 1);
                    if (elig) begin
                        if (gnt[i]) begin
                            chk(LAT, "fairness_wait", int'(waitc[i] < NR), 1);
                            waitc[i] = 0;
                        end else if (gnt != '0) begin
                            waitc[i]++;
                        end
                    end else begin
                        waitc[i] = 0;
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    if (gnt[i]) begin
                        seen[i]   = 1'b1;
                        last_g[i] = d;
                    end
                end
            end
        end
    end

    initial begin
        foreach (tmap[r, c]) tmap[r][c] = TW'($urandom_range(1, 254));
        tmap[3][5] = 8'd2;
        for (int t = 0; t < 60000 && !(lane[0].done_l && lane[1].done_l); t++) @(posedge clk);
        if (!(lane[0].done_l && lane[1].done_l)) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for stimulus to complete (cycle %0d)", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_lookup_arbiter.md
Name: tile_lookup_arbiter

Overview:
Shares the single read port of the background tile map (12 rows x 17 columns of byte tile codes) between movement and collision clients. Clients are the left/right mover, the jump/gravity mover and the token collector. Each client issues a row/column lookup and receives the tile code back. The block arbitrates round-robin, pipelines lookups to the map's read latency and substitutes the border code for off-map coordinates.

Parameters:
NUM_REQ, 3, number of requesting clients
ROWS, 12, tile map rows
COLS, 17, tile map columns
ROW_BITS, 4, row index width
COL_BITS, 5, column index width
TILE_BITS, 8, tile code width
READ_LATENCY, 1, map read latency in cycles (legal 1..3)
BDR, 0, tile code returned for out-of-range coordinates

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-client lookup request, level
req_row  in  NUM_REQ*ROW_BITS  per-client row index; client i uses slice i
req_col  in  NUM_REQ*COL_BITS  per-client column index; client i uses slice i
gnt  out  NUM_REQ  one-hot, one-cycle pulse when client's lookup is issued
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse when client's tile is valid
rsp_tile  out  TILE_BITS  tile code, valid only with rsp_valid
mem_rd_en  out  1  map read strobe
mem_row  out  ROW_BITS  map read row
mem_col  out  COL_BITS  map read column
mem_tile  in  TILE_BITS  map read data, READ_LATENCY cycles after mem_rd_en
busy  out  1  high while any lookup is in flight

Behaviour:
- Reset (async, high): gnt=0, rsp_valid=0, rsp_tile=0, mem_rd_en=0, mem_row=0, mem_col=0, busy=0. In-flight pipeline is cleared. RR pointer = NUM_REQ-1, so client 0 has top priority on the first arbitration.
- Reset mid-operation drops all in-flight lookups. No rsp_valid is produced for them after reset deasserts.
- Client i is eligible when req[i]=1 and it has no lookup in flight.
- Each cycle, at most one grant goes to the first eligible client searching from pointer+1 with wrap (NUM_REQ-1 -> 0).
- On grant (registered): gnt[i]=1 for one cycle. Row/col are captured from client i's slices in the grant cycle. The pointer is updated to i.
- In-range lookup (row<ROWS and col<COLS): mem_rd_en=1, mem_row/mem_col driven in the same cycle as gnt.
- Out-of-range lookup: mem_rd_en=0. The response carries BDR with the same latency as an in-range lookup.
- Response: rsp_valid[i] and rsp_tile appear exactly READ_LATENCY+1 cycles after gnt[i], with rsp_tile registered from mem_tile.
  - Tags (client index, out-of-range flag) travel in a READ_LATENCY-deep shift pipeline.
  - Back-to-back grants to different clients are allowed every cycle, so up to READ_LATENCY+1 lookups are in flight.
- Client protocol: hold req, row and col stable until gnt. Coordinates after gnt are don't-care. A client wanting another lookup keeps or re-raises req after its rsp_valid. The arbiter ignores req[i] while client i is in flight, including in the rsp_valid cycle.
- Fairness: a continuously requesting client is granted within NUM_REQ grant cycles.
- Simultaneous events: a grant and an unrelated response in the same cycle are independent. A client's rsp_valid and its new grant never coincide (earliest re-grant is the cycle after rsp_valid).
- busy = OR of in-flight tags, registered.
- All index comparisons are unsigned. Row and column widths are not truncated before the range check.

Test Plan:
- Reset, req=001, row0=3, col0=5, map[3][5]=2 -> gnt=001 at cycle t, mem_rd_en at t, rsp_valid=001 with rsp_tile=2 at t+2 (READ_LATENCY=1).
- req=111 held continuously from reset -> grant order 0,1,2,0,1,2; each gnt[i] is followed by rsp_valid[i] two cycles later with the correct tile; no client re-granted before its response.
- Client 1 requests row=12, col=4, then row=2, col=17 -> mem_rd_en stays 0; rsp_tile=BDR=0 at gnt+2 for both.
- Clients 0 and 2 in flight, assert reset for one cycle -> all outputs 0 immediately; no rsp_valid afterwards; after release with req=100, the first grant goes to client 2.
- READ_LATENCY=3, req=111 -> grants on three consecutive cycles, responses on three consecutive cycles 4 cycles after each grant, busy high throughout, low one cycle after the last rsp_valid.
- req=010 toggling with req=001 held -> client 0 never waits more than 3 grant cycles; fairness counter checked over 1000 random cycles.
